mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 152 +++++++++++++++
 tb/tb_mem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Fixed-latency single-port word memory responder with byte-enabled writes.
// Optional misaligned-access error reporting via MEM_RESPONDER_ALIGN_CHECK_EN.
module mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int          DEPTH     = 2 ** ADDR_BITS;
    localparam logic [3:0]  CNT_START = 4'(LATENCY - 1);

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [3:0]             be_q, be_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   write_q, write_d;
    logic                   misalign_q, misalign_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   mem_we;

    logic [31:0]            mem [DEPTH];

    logic [ADDR_BITS-1:0]   req_index;
    logic                   req_misalign;
    logic                   unused_addr_bits;

    assign req_index        = mem_address[ADDR_BITS+1:2];
    // Upper bits alias away; the low two are consumed only by the alignment check.
    assign unused_addr_bits = ^{mem_address[31:ADDR_BITS+2], mem_address[1:0]};

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign req_misalign = |mem_address[1:0];
`else
    assign req_misalign = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        misalign_d = misalign_q;
        rdata_d    = rdata_q;
        mem_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d     = req_index;
                    be_d       = mem_byte_enable;
                    wdata_d    = mem_wdata;
                    write_d    = mem_write;
                    misalign_d = req_misalign;
                    if (LATENCY == 1) begin
                        // Entering RESP directly, so the read uses the live request.
                        state_d = RESP;
                        cnt_d   = 4'd0;
                        if (!mem_write && !req_misalign) begin
                            rdata_d = mem[req_index];
                        end
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_START;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                    if (!write_q && !misalign_q) begin
                        rdata_d = mem[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                mem_we  = write_q && !misalign_q;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            write_q    <= 1'b0;
            misalign_q <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            misalign_q <= misalign_d;
            rdata_q    <= rdata_d;
        end
    end

    // NOTE: the storage array has no reset; contents survive rst, only an in-flight write is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_resp  = (state_q == RESP);

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign mem_err = mem_resp && misalign_q;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the driver queues expected responses,
// a negedge monitor pops and compares on every mem_resp.
module tb_mem_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp, mem_err;

    mem_responder #(.ADDR_BITS(8), .LATENCY(LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .mem_err         (mem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_rdata = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Latency counts the accept edge as cycle 1, so resp after edge acc+2 means 3.
    always @(negedge clk) begin
        if (mem_resp === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("latency", 32'(cyc - mon_e.acc + 1), 32'(LAT));
                check("rdata", mem_rdata, mon_e.rdata);
                check("err", {31'd0, mem_err}, {31'd0, mon_e.err});
            end
        end else if (mem_err !== 1'b0) begin
            check("err_without_resp", {31'd0, mem_err}, 32'd0);
        end
    end

    task automatic idle_inputs();
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = 32'd0;
        mem_byte_enable = 4'd0;
        mem_wdata       = 32'd0;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] exp_word, input bit scramble);
        exp_t e;
        bit   got;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        e.err = |addr[1:0];
`else
        e.err = 1'b0;
`endif
        @(negedge clk);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_byte_enable = be;
        mem_wdata       = wd;
        e.acc = cyc + 1;
        if (!wr && !e.err) model_rdata = exp_word;
        e.rdata = model_rdata;
        sb.push_back(e);
        if (scramble) begin
            @(negedge clk);
            mem_address     = addr + 32'd4;
            mem_wdata       = ~wd;
            mem_byte_enable = ~be;
        end
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_resp === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("resp_timeout", 32'd0, 32'd1);
        idle_inputs();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        req(1'b0, 1'b1, addr, be, wd, 32'd0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_word);
        req(1'b1, 1'b0, addr, 4'd0, 32'd0, exp_word, 1'b0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rdata", mem_rdata, 32'd0);
        check("reset_resp", {31'd0, mem_resp}, 32'd0);
        check("reset_err", {31'd0, mem_err}, 32'd0);
        rst = 1'b0;

        // Full-word write then read back.
        wr(32'h10, 4'b1111, 32'hDEADBEEF);
        rd(32'h10, 32'hDEADBEEF);

        // Partial byte-lane merge.
        wr(32'h20, 4'b1111, 32'h11223344);
        wr(32'h20, 4'b0101, 32'hAABBCCDD);
        rd(32'h20, 32'h11BB33DD);

        // Address aliasing modulo 2**(ADDR_BITS+2).
        wr(32'h0, 4'b1111, 32'h5);
        rd(32'h400, 32'h5);

        // Abort a write by reset while it sits in WAIT.
        wr(32'h8, 4'b1111, 32'h0);
        rd(32'h10, 32'hDEADBEEF);
        @(negedge clk);
        mem_write       = 1'b1;
        mem_address     = 32'h8;
        mem_byte_enable = 4'b1111;
        mem_wdata       = 32'hFFFFFFFF;
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        check("abort_resp", {31'd0, mem_resp}, 32'd0);
        check("abort_err", {31'd0, mem_err}, 32'd0);
        check("abort_rdata", mem_rdata, 32'd0);
        rst = 1'b0;
        model_rdata = 32'd0;
        repeat (5) @(negedge clk);
        rd(32'h8, 32'h0);

        // Read and write together behave as a write; rdata holds.
        req(1'b1, 1'b1, 32'h4, 4'b1111, 32'h12345678, 32'd0, 1'b0);
        rd(32'h4, 32'h12345678);

        // Zero byte enables complete but change nothing.
        wr(32'h20, 4'b0000, 32'hFFFFFFFF);
        rd(32'h20, 32'h11BB33DD);

        // Inputs disturbed after accept must not leak into the result.
        wr(32'h34, 4'b1111, 32'h01010101);
        req(1'b0, 1'b1, 32'h30, 4'b1111, 32'hCAFEF00D, 32'd0, 1'b1);
        rd(32'h30, 32'hCAFEF00D);
        rd(32'h34, 32'h01010101);

        // Misaligned accesses.
        wr(32'h13, 4'b1111, 32'h77777777);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        rd(32'h11, 32'd0);
        rd(32'h10, 32'hDEADBEEF);
`else
        rd(32'h11, 32'h77777777);
        rd(32'h10, 32'h77777777);
`endif

        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) check("scoreboard_drain", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
